// File: rtl/sd_prog_detector_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Defaults describe the legacy fixed detector: 1011, overlapping.
package sd_pkg;
  localparam logic [3:0] SD_RST_PATTERN = 4'b1011;
  localparam int         SD_RST_LEN     = 4;
  localparam bit         SD_RST_OVERLAP = 1'b1;

  // Width needed to hold a length in 0..pat_w inclusive.
  function automatic int sd_len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
endpackage

// File: rtl/sd_sat_counter.sv
// Saturating event counter; a clear that coincides with an increment
// leaves the count at 1 so the coincident event is not lost.
module sd_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                          count_d = inc ? CNT_W'(1) : '0;
    else if (inc && count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/sd_prog_detector.sv
// Runtime-programmable serial pattern detector: compares the last len_q
// accepted bits against a loadable pattern, overlapping or not.
module sd_prog_detector
  import sd_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(SD_RST_PATTERN),
  parameter int               RST_LEN     = SD_RST_LEN,
  parameter bit               RST_OVERLAP = SD_RST_OVERLAP,
  localparam int              LEN_W       = sd_len_w(PAT_W)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sequence_in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             count_clr,
  output logic             detector_out,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);
  logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d, hist_sh, len_mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc, len_q, len_d;
  logic             ovl_q, ovl_d, det_q, det_d, err_q, err_d;
  logic             accept, cfg_ok, match;

  always_comb begin
    accept   = in_valid && !cfg_load;
    cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    hist_sh  = {hist_q[PAT_W-2:0], sequence_in};
    fill_inc = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    // Pattern bits above len_q-1 are masked out of the compare.
    len_mask = ~({PAT_W{1'b1}} << len_q);
    match    = accept && (fill_inc >= len_q) &&
               (((hist_sh ^ pat_q) & len_mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    det_d  = match;
    err_d  = cfg_load && !cfg_ok;

    // A config load always swallows the input bit of its cycle.
    if (cfg_load) begin
      if (cfg_ok) begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        hist_d = '0;
        fill_d = '0;
      end
    end else if (accept) begin
      hist_d = hist_sh;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PATTERN;
      len_q  <= LEN_W'(RST_LEN);
      ovl_q  <= RST_OVERLAP;
      det_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      det_q  <= det_d;
      err_q  <= err_d;
    end
  end

  sd_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (match),
    .clr     (count_clr),
    .count   (match_count)
  );

  assign detector_out = det_q;
  assign cfg_err      = err_q;
endmodule
